// File: rtl/pipeline_stall_ctrl_if.sv
// Stall/flush control bundle between the hazard/memory sources and the pipeline
// registers. master = stall controller, slave = pipeline datapath side.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use_hz;
    logic             branch_taken_ex;
    logic             md_start_ex;
    logic             md_use_id;
    logic             mem_access_mem;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  load_use_hz, branch_taken_ex, md_start_ex, md_use_id,
               mem_access_mem, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush,
               md_busy, md_done, stall_cycles
    );

    modport slave (
        output load_use_hz, branch_taken_ex, md_start_ex, md_use_id,
               mem_access_mem, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush,
               md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline with mult/div interlock FSM.
// Define STALL_STATS_EN to build the saturating stall_cycles counter; otherwise it reads 0.
module pipeline_stall_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_stall_ctrl_if.master bus
);
    typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} mdState_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

    mdState_t   mdState, mdStateNext;
    logic [7:0] mdCnt, mdCntNext;
    logic       mdBusy, mdAccept, freeze, stallReq;
    logic       pcWrite, ifIdWrite, idExWrite, exMemWrite;
    logic       ifIdFlush, idExFlush, memWbFlush;

    always_ff @(posedge clk) begin
        if (rst) mdState <= RUN;
        else     mdState <= mdStateNext;
    end

    always_ff @(posedge clk) begin
        mdCnt <= mdCntNext;
    end

    // Stage enables/flushes: memory freeze outranks branch, branch outranks stalls.
    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        memWbFlush = 1'b0;
        mdBusy     = (mdState != RUN);
        freeze     = bus.mem_access_mem & ~bus.dmem_ready;
        stallReq   = bus.load_use_hz | (mdBusy & bus.md_use_id);
        if (rst) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            memWbFlush = 1'b1;
        end else if (freeze) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
        end else if (bus.branch_taken_ex) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
        end else if (stallReq) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end
    end

    // Mult/div tracker: the countdown keeps running through memory freezes.
    always_comb begin
        mdStateNext = mdState;
        mdCntNext   = mdCnt;
        mdAccept    = exMemWrite & ~bus.branch_taken_ex & bus.md_start_ex & (mdState == RUN);
        case (mdState)
            RUN: begin
                if (mdAccept) begin
                    mdStateNext = MD_BUSY;
                    mdCntNext   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (mdCnt == 8'd0) mdStateNext = MD_DONE;
                else               mdCntNext   = mdCnt - 8'd1;
            end
            MD_DONE: mdStateNext = RUN;
            default: mdStateNext = RUN;
        endcase
    end

    assign bus.pc_write     = pcWrite;
    assign bus.if_id_write  = ifIdWrite;
    assign bus.id_ex_write  = idExWrite;
    assign bus.ex_mem_write = exMemWrite;
    assign bus.if_id_flush  = ifIdFlush;
    assign bus.id_ex_flush  = idExFlush;
    assign bus.mem_wb_flush = memWbFlush;
    assign bus.md_busy      = ~rst & mdBusy;
    assign bus.md_done      = ~rst & (mdState == MD_DONE);

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] stallCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)           stallCnt <= '0;
        else if (!pcWrite) stallCnt <= satInc(stallCnt);
    end

    assign bus.stall_cycles = rst ? '0 : stallCnt;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector scoreboard bench for pipeline_stall_ctrl (MD_LAT=4, CNT_W=3).
// Expected stall_cycles follows STALL_STATS_EN the same way the design does.
module tb_pipeline_stall_ctrl;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, md_busy, md_done}
    localparam logic [8:0] RSTV  = 9'b0000_111_00;
    localparam logic [8:0] RUNV  = 9'b1111_000_00;
    localparam logic [8:0] RUNB  = 9'b1111_000_10;
    localparam logic [8:0] RUND  = 9'b1111_000_11;
    localparam logic [8:0] STLB  = 9'b0011_010_10;
    localparam logic [8:0] STLD  = 9'b0011_010_11;
    localparam logic [8:0] STL   = 9'b0011_010_00;
    localparam logic [8:0] BRV   = 9'b1111_110_00;
    localparam logic [8:0] FRZ   = 9'b0000_001_00;

    typedef struct {
        logic [8:0]       outs;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t e;
    logic [8:0] act;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] expCnt(input int n);
`ifdef STALL_STATS_EN
        return CNT_W'(n);
`else
        return CNT_W'(0) & CNT_W'(n);
`endif
    endfunction

    task automatic step(input logic r, input logic lu, input logic br, input logic ms,
                        input logic mu, input logic ma, input logic dr,
                        input logic [8:0] o, input int n, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.load_use_hz     = lu;
        bus.branch_taken_ex = br;
        bus.md_start_ex     = ms;
        bus.md_use_id       = mu;
        bus.mem_access_mem  = ma;
        bus.dmem_ready      = dr;
        x.outs = o;
        x.cnt  = expCnt(n);
        x.name = name;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                   bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush,
                   bus.md_busy, bus.md_done};
            checks++;
            if (act !== e.outs) begin
                failures++;
                $display("FAIL %s outputs got=%b expected=%b", e.name, act, e.outs);
            end
            checks++;
            if (bus.stall_cycles !== e.cnt) begin
                failures++;
                $display("FAIL %s stall_cycles got=%0d expected=%0d", e.name, bus.stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        bus.load_use_hz     = 1'b0;
        bus.branch_taken_ex = 1'b0;
        bus.md_start_ex     = 1'b0;
        bus.md_use_id       = 1'b0;
        bus.mem_access_mem  = 1'b0;
        bus.dmem_ready      = 1'b0;

        //   rst lu br ms mu ma dr  outs  cnt  name
        step(1, 0, 0, 0, 0, 0, 0, RSTV, 0, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, RSTV, 0, "reset1");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 0, "idle0");
        step(0, 1, 0, 0, 0, 0, 0, STL,  0, "load_use");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 1, "after_load_use");
        step(0, 1, 1, 0, 0, 0, 0, BRV,  1, "branch_over_load_use");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 1, "after_branch");
        step(0, 0, 0, 1, 1, 0, 0, RUNV, 1, "md_start");
        step(0, 0, 0, 1, 1, 0, 0, STLB, 1, "md_busy0_restart_ignored");
        step(0, 0, 0, 0, 1, 0, 0, STLB, 2, "md_busy1");
        step(0, 0, 0, 0, 1, 0, 0, STLB, 3, "md_busy2");
        step(0, 0, 0, 0, 1, 0, 0, STLB, 4, "md_busy3");
        step(0, 0, 0, 0, 1, 0, 0, STLD, 5, "md_done");
        step(0, 0, 0, 0, 1, 0, 0, RUNV, 6, "md_use_advances");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 6, "idle1");
        step(0, 0, 1, 0, 0, 1, 0, FRZ,  6, "freeze0_branch_held");
        step(0, 0, 1, 0, 0, 1, 0, FRZ,  7, "freeze1_branch_held");
        step(0, 0, 1, 0, 0, 1, 0, FRZ,  7, "freeze2_count_saturated");
        step(0, 0, 1, 0, 0, 1, 1, BRV,  7, "branch_after_freeze");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 7, "idle2");
        step(0, 0, 0, 1, 0, 1, 0, FRZ,  7, "md_start_in_freeze");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 7, "no_accept_in_freeze");
        step(0, 0, 0, 1, 0, 0, 0, RUNV, 7, "md_start2");
        step(0, 0, 0, 0, 0, 0, 0, RUNB, 7, "busy_before_reset");
        step(1, 0, 0, 0, 0, 0, 0, RSTV, 0, "reset_mid_busy");
        step(0, 0, 0, 1, 0, 0, 0, RUNV, 0, "md_start_after_reset");
        step(0, 0, 0, 0, 0, 0, 0, RUNB, 0, "busy_a");
        step(0, 0, 0, 0, 0, 0, 0, RUNB, 0, "busy_b");
        step(0, 0, 0, 0, 0, 0, 0, RUNB, 0, "busy_c");
        step(0, 0, 0, 0, 0, 0, 0, RUNB, 0, "busy_d");
        step(0, 0, 0, 0, 0, 0, 0, RUND, 0, "done_no_use");
        step(0, 0, 1, 1, 0, 0, 0, BRV,  0, "branch_blocks_start");
        step(0, 0, 0, 0, 0, 0, 0, RUNV, 0, "no_accept_on_branch");

        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
